// File: rtl/alu_arbiter_pkg.sv
// Shared CPU profile: datapath width, ALU opcodes and the arbiter's buffer states.
package alu_arbiter_pkg;

  localparam int XLEN            = 32;
  localparam int ALU_ARB_MAX_REQ = 8;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU
  } alu_op_e;

  typedef enum logic {
    ARB_EMPTY,
    ARB_FULL
  } arb_state_e;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU, XLEN wide; zero latency, no flow control.
// Shift amounts use the low log2(XLEN) bits of operand b.
module alu
  import alu_arbiter_pkg::*;
(
  input  alu_op_e           op_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [XLEN-1:0]   result_o
);

  localparam int SH_W = $clog2(XLEN);

  logic [SH_W-1:0] shamt;
  assign shamt = b_i[SH_W-1:0];

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
      ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches req from ptr upward with wrap,
// returns a one-hot grant and its index; all-zero grant when en is low.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic          found;
  int            j;
  logic [IW-1:0] j_idx;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    j_idx = '0;
    if (en_i) begin
      for (int k = 0; k < N; k++) begin
        j     = (int'(ptr_i) + k) % N;
        j_idx = IW'(j);
        if (!found && req_i[j_idx]) begin
          found        = 1'b1;
          gnt_o[j_idx] = 1'b1;
          idx_o        = j_idx;
        end
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU across NUM_REQ requesters; 1-cycle registered tagged response, one-entry buffer.
// Stalled response blocks all grants; ALU_ARB_PRIO0_EN gives requester 0 fixed top priority.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  alu_op_e [NUM_REQ-1:0]          req_op_i,
  input  logic [NUM_REQ-1:0][XLEN-1:0]   req_a_i,
  input  logic [NUM_REQ-1:0][XLEN-1:0]   req_b_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [ID_W-1:0]                rsp_id_o,
  output logic [XLEN-1:0]                rsp_result_o
);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [XLEN-1:0]  result_q, result_d;

  logic               can_accept, accept, ptr_adv, rr_en;
  logic [NUM_REQ-1:0] rr_req, rr_gnt, gnt;
  logic [ID_W-1:0]    rr_idx, gnt_idx;
  logic [XLEN-1:0]    alu_res;

  // A full buffer can still accept when its response leaves this same cycle.
  assign can_accept = (state_q == ARB_EMPTY) || rsp_ready_i;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_rr (
    .req_i (rr_req),
    .ptr_i (ptr_q),
    .en_i  (rr_en),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx)
  );

`ifdef ALU_ARB_PRIO0_EN
  assign rr_req = req_valid_i & {{(NUM_REQ-1){1'b1}}, 1'b0};
  assign rr_en  = can_accept & ~req_valid_i[0];

  always_comb begin
    gnt     = rr_gnt;
    gnt_idx = rr_idx;
    ptr_adv = |rr_gnt;
    if (can_accept && req_valid_i[0]) begin
      gnt     = NUM_REQ'(1);
      gnt_idx = '0;
      ptr_adv = 1'b0;
    end
  end
`else
  assign rr_req  = req_valid_i;
  assign rr_en   = can_accept;
  assign gnt     = rr_gnt;
  assign gnt_idx = rr_idx;
  assign ptr_adv = |rr_gnt;
`endif

  assign accept      = |gnt;
  assign req_ready_o = gnt;

  // With no grant the index is 0, so requester 0 drives the idle ALU.
  alu u_alu (
    .op_i     (req_op_i[gnt_idx]),
    .a_i      (req_a_i[gnt_idx]),
    .b_i      (req_b_i[gnt_idx]),
    .result_o (alu_res)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    result_d = result_q;
    if (accept) begin
      state_d  = ARB_FULL;
      id_d     = gnt_idx;
      result_d = alu_res;
    end else if (state_q == ARB_FULL && rsp_ready_i) begin
      state_d = ARB_EMPTY;
    end
    if (ptr_adv) begin
      ptr_d = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ARB_EMPTY;
      ptr_q    <= '0;
      id_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      result_q <= result_d;
    end
  end

  assign rsp_valid_o  = (state_q == ARB_FULL);
  assign rsp_id_o     = id_q;
  assign rsp_result_o = result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter (NUM_REQ=3): directed scenarios plus a random phase,
// all cycles checked against a transaction-level model of the arbiter.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int IW = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [N-1:0]           req_valid = '0;
  logic [N-1:0]           req_ready;
  alu_op_e [N-1:0]        req_op;
  logic [N-1:0][XLEN-1:0] req_a = '0;
  logic [N-1:0][XLEN-1:0] req_b = '0;
  logic                   rsp_valid;
  logic                   rsp_ready = 1'b1;
  logic [IW-1:0]          rsp_id;
  logic [XLEN-1:0]        rsp_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_op_i     (req_op),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_id_o     (rsp_id),
    .rsp_result_o (rsp_result)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_alu(input alu_op_e op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    int sh;
    sh = int'(b % XLEN);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << sh;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return $unsigned($signed(a) >>> sh);
      ALU_SLT:  return ($signed(a) < $signed(b)) ? XLEN'(1) : XLEN'(0);
      ALU_SLTU: return (a < b) ? XLEN'(1) : XLEN'(0);
      default:  return '0;
    endcase
  endfunction

  // Winner among valid requesters, or -1 when nobody is asking.
  function automatic int pick(input logic [N-1:0] v, input int ptr);
`ifdef ALU_ARB_PRIO0_EN
    if (v[0]) return 0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (ptr + k) % N;
      if (j != 0 && v[j]) return j;
    end
`else
    for (int k = 0; k < N; k++) begin
      int j;
      j = (ptr + k) % N;
      if (v[j]) return j;
    end
`endif
    return -1;
  endfunction

  bit              m_valid = 1'b0, n_valid = 1'b0;
  int              m_id = 0, n_id = 0, m_ptr = 0, n_ptr = 0;
  logic [XLEN-1:0] m_res = '0, n_res = '0;
  int              g;
  logic [N-1:0]    exp_rdy;

  always @(negedge clk) begin
    if (!rst_n) begin
      n_valid = 1'b0; n_id = 0; n_res = '0; n_ptr = 0;
    end else begin
      g = (!m_valid || rsp_ready) ? pick(req_valid, m_ptr) : -1;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
      if (m_valid) begin
        chk("rsp_id", 64'(rsp_id), 64'(m_id));
        chk("rsp_result", 64'(rsp_result), 64'(m_res));
      end
      n_valid = m_valid; n_id = m_id; n_res = m_res; n_ptr = m_ptr;
      if (g >= 0) begin
        n_valid = 1'b1;
        n_id    = g;
        n_res   = ref_alu(req_op[g], req_a[g], req_b[g]);
`ifdef ALU_ARB_PRIO0_EN
        if (g != 0) n_ptr = (g + 1) % N;
`else
        n_ptr = (g + 1) % N;
`endif
      end else if (m_valid && rsp_ready) begin
        n_valid = 1'b0;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_id <= 0; m_res <= '0; m_ptr <= 0;
    end else begin
      m_valid <= n_valid; m_id <= n_id; m_res <= n_res; m_ptr <= n_ptr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input alu_op_e op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b);
    req_op[i] = op;
    req_a[i]  = a;
    req_b[i]  = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_id", 64'(rsp_id), 64'd0);
    chk("reset_rsp_result", 64'(rsp_result), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  int              exp_id;
  logic [XLEN-1:0] held_res;
  logic [IW-1:0]   held_id;
  logic [N-1:0]    hold;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) req_op[i] = ALU_ADD;
    do_reset();

    // Single request, 1-cycle latency.
    set_req(0, ALU_ADD, 32'd5, 32'd7);
    req_valid = 3'b001;
    #1 chk("t1_ready", 64'(req_ready), 64'b001);
    tick();
    req_valid = '0;
    chk("t1_valid", 64'(rsp_valid), 64'd1);
    chk("t1_id", 64'(rsp_id), 64'd0);
    chk("t1_result", 64'(rsp_result), 64'd12);
    tick();

    // Two requesters always valid, alternating grants at full throughput.
    do_reset();
    set_req(0, ALU_SUB, 32'd10, 32'd3);
    set_req(1, ALU_XOR, 32'hF0, 32'hFF);
    req_valid = 3'b011;
    for (int k = 0; k < 6; k++) begin
      tick();
`ifdef ALU_ARB_PRIO0_EN
      exp_id = 0;
`else
      exp_id = k % 2;
`endif
      chk("t2_valid", 64'(rsp_valid), 64'd1);
      chk("t2_id", 64'(rsp_id), 64'(exp_id));
      chk("t2_result", 64'(rsp_result), (exp_id == 0) ? 64'd7 : 64'h0F);
    end

    // Stalled response: no grants, stable output, immediate accept on release.
    rsp_ready = 1'b0;
    held_res  = rsp_result;
    held_id   = rsp_id;
    #1 chk("t3_ready_stall", 64'(req_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_ready_stall", 64'(req_ready), 64'd0);
      chk("t3_result_hold", 64'(rsp_result), 64'(held_res));
      chk("t3_id_hold", 64'(rsp_id), 64'(held_id));
    end
    rsp_ready = 1'b1;
    #1 chk("t3_ready_release", 64'(req_ready), 64'b001);
    tick();
    chk("t3_id_after", 64'(rsp_id), 64'd0);
    chk("t3_result_after", 64'(rsp_result), 64'd7);

    // Pointer wrap with requesters 0 and 2 only.
    do_reset();
    set_req(1, ALU_ADD, 32'd1, 32'd1);
    req_valid = 3'b010;
    tick();
    chk("t4_id_first", 64'(rsp_id), 64'd1);
    chk("t4_result_first", 64'(rsp_result), 64'd2);
    set_req(0, ALU_ADD, 32'd1, 32'd2);
    set_req(2, ALU_SRA, 32'h8000_0000, 32'd4);
    req_valid = 3'b101;
    for (int k = 0; k < 4; k++) begin
      tick();
`ifdef ALU_ARB_PRIO0_EN
      exp_id = 0;
`else
      exp_id = (k % 2 == 0) ? 2 : 0;
`endif
      chk("t4_id", 64'(rsp_id), 64'(exp_id));
      chk("t4_result", 64'(rsp_result), (exp_id == 2) ? 64'hF800_0000 : 64'd3);
    end

    // Asynchronous reset while the buffer is full.
    rsp_ready = 1'b0;
    tick();
    chk("t5_full", 64'(rsp_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("t5_async_valid", 64'(rsp_valid), 64'd0);
    chk("t5_async_result", 64'(rsp_result), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    req_valid = 3'b111;
    rsp_ready = 1'b1;
    #1 chk("t5_first_grant", 64'(req_ready), 64'b001);
    tick();
    chk("t5_first_id", 64'(rsp_id), 64'd0);

`ifdef ALU_ARB_PRIO0_EN
    // Fixed priority for requester 0.
    do_reset();
    set_req(0, ALU_ADD, 32'd2, 32'd2);
    set_req(1, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    req_valid = 3'b011;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t6_id_prio", 64'(rsp_id), 64'd0);
    end
    req_valid = 3'b010;
    #1 chk("t6_ready_req1", 64'(req_ready), 64'b010);
    tick();
    chk("t6_id_req1", 64'(rsp_id), 64'd1);
    chk("t6_slt", 64'(rsp_result), 64'd1);
`endif

    // Random traffic; pending requesters keep their fields stable.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      hold = req_valid & ~req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (!hold[i]) begin
          req_op[i] = alu_op_e'(4'($urandom_range(0, 9)));
          req_a[i]  = $urandom;
          req_b[i]  = ($urandom_range(0, 1) == 1) ? $urandom : XLEN'($urandom_range(0, 40));
        end
        req_valid[i] = ($urandom_range(0, 9) < 6);
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
